// File: rtl/intr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intr_pkg
// Description : Shared definitions for the interrupt scheduler: handler
//               state encoding, source index constants and mask reset value.
// Revision    : 1.0 - initial release
// ============================================================================
package intr_pkg;

    // Handler state. Explicit 2-bit encoding; the fourth code is unused and
    // recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        SERVICE = 2'd2
    } state_e;

    // Bit positions of each source in pending / mask / take vectors.
    localparam int SRC1 = 0;
    localparam int SRC2 = 1;

    // Both sources disabled out of reset.
    localparam logic [1:0] MASK_RST = 2'b00;

endpackage
`default_nettype wire

// File: rtl/edge_rise.sv
`default_nettype none
// ============================================================================
// Module      : edge_rise
// Description : 1-bit rising-edge detector. Registers the previous level of
//               d and flags a cycle where d is high but was low last cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk    in   1  system clock, rising edge
//   reset  in   1  asynchronous active-low reset (history register -> 0)
//   d      in   1  level input, already synchronous to clk
//   rise   out  1  d & ~d_previous (combinational from d and history)
// ============================================================================
module edge_rise (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= 1'b0;
        end else begin
            r_q <= d;
        end
    end

    // A level held high through reset release counts as an edge, because the
    // history register starts at 0.
    assign rise = d & ~r_q;

endmodule
`default_nettype wire

// File: rtl/intr_sched.sv
`default_nettype none
// ============================================================================
// Module      : intr_sched
// Description : Interrupt scheduler for the single-cycle CPU datapath.
//               Latches rising edges of irq1 / irq2 (timer expiry folds into
//               source 2), arbitrates by fixed priority (source 1 first),
//               issues one vector-select strobe when the stack is free and
//               then holds off until return-from-interrupt.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1      system clock, rising edge
//   reset       in   1      asynchronous active-low reset
//   irq1        in   1      external request 1 (level, rising edge = event)
//   irq2        in   1      external request 2 (level, rising edge = event)
//   timer_tick  in   1      one-cycle timer expiry, a source-2 event
//   stack_busy  in   1      control unit uses the stack this cycle
//   reti        in   1      one-cycle return-from-interrupt pulse
//   we_mask     in   1      mask register write enable
//   mask_in     in   2      new mask (bit0 = source 1, bit1 = source 2)
//   s_intr1     out  1      one-cycle strobe: take vector 1
//   s_intr2     out  1      one-cycle strobe: take vector 2
//   in_service  out  1      a handler is active (TAKE or SERVICE)
//   pending     out  2      latched, not yet taken events
//   mask        out  2      current enable mask
//   lost_cnt    out  CNT_W  saturating count of events dropped on a source
//                           that was already pending
// All outputs come straight from flops.
// ============================================================================
module intr_sched
    import intr_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq1,
    input  logic             irq2,
    input  logic             timer_tick,
    input  logic             stack_busy,
    input  logic             reti,
    input  logic             we_mask,
    input  logic [1:0]       mask_in,
    output logic             s_intr1,
    output logic             s_intr2,
    output logic             in_service,
    output logic [1:0]       pending,
    output logic [1:0]       mask,
    output logic [CNT_W-1:0] lost_cnt
);

    localparam logic [CNT_W-1:0] c_lost_max = '1;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_e           r_state;
    logic             r_s_intr1;
    logic             r_s_intr2;
    logic             r_in_service;
    logic [1:0]       r_pending;
    logic [1:0]       r_mask;
    logic [CNT_W-1:0] r_lost_cnt;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [1:0]       w_irq;
    logic [1:0]       w_edge;
    logic [1:0]       w_rise;
    logic [1:0]       w_eligible;
    logic [1:0]       w_take;
    logic [1:0]       w_lost;
    logic [1:0]       w_lost_n;
    logic [CNT_W:0]   w_lost_sum;
    logic [CNT_W-1:0] w_lost_nxt;
    state_e           w_state_nxt;

    // ------------------------------------------------------------------
    // Edge detection, one detector per external line
    // ------------------------------------------------------------------
    assign w_irq = {irq2, irq1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            edge_rise u_edge_rise (
                .clk   (clk),
                .reset (reset),
                .d     (w_irq[gi]),
                .rise  (w_edge[gi])
            );
        end
    endgenerate

    // The timer shares the source-2 vector; its pulse is already one cycle
    // wide so it needs no edge detector.
    assign w_rise[SRC1] = w_edge[SRC1];
    assign w_rise[SRC2] = w_edge[SRC2] | timer_tick;

    // Arbitration looks only at the registered mask, so a mask write takes
    // effect one cycle after it is loaded.
    assign w_eligible = r_pending & r_mask;

    // ------------------------------------------------------------------
    // Handler FSM: next state and take decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 2'b00;
        case (r_state)
            IDLE: begin
                if ((w_eligible != 2'b00) && !stack_busy) begin
                    w_state_nxt = TAKE;
                    if (w_eligible[SRC1]) begin
                        w_take[SRC1] = 1'b1;
                    end else begin
                        w_take[SRC2] = 1'b1;
                    end
                end
            end
            TAKE: begin
                // The strobe is visible for exactly this cycle; reti here is
                // meaningless and ignored.
                w_state_nxt = SERVICE;
            end
            SERVICE: begin
                if (reti) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Lost-event accounting
    // ------------------------------------------------------------------
    // An event is lost only if its pending bit is still set after this edge
    // would have consumed it; a rise on the source being taken right now is a
    // fresh event and re-arms pending instead.
    assign w_lost   = w_rise & r_pending & ~w_take;
    assign w_lost_n = {1'b0, w_lost[SRC1]} + {1'b0, w_lost[SRC2]};

    // One extra bit of headroom so the saturation test sees the carry.
    assign w_lost_sum = {1'b0, r_lost_cnt} + {{(CNT_W-1){1'b0}}, w_lost_n};
    assign w_lost_nxt = (w_lost_sum > {1'b0, c_lost_max}) ? c_lost_max
                                                           : w_lost_sum[CNT_W-1:0];

    // ------------------------------------------------------------------
    // Output and bookkeeping registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s_intr1    <= 1'b0;
            r_s_intr2    <= 1'b0;
            r_in_service <= 1'b0;
            r_pending    <= 2'b00;
            r_mask       <= MASK_RST;
            r_lost_cnt   <= '0;
        end else begin
            r_s_intr1    <= w_take[SRC1];
            r_s_intr2    <= w_take[SRC2];
            r_in_service <= (w_state_nxt != IDLE);
            // Set has priority over the take-clear of the same bit.
            r_pending    <= (r_pending & ~w_take) | w_rise;
            if (we_mask) begin
                r_mask <= mask_in;
            end
            r_lost_cnt   <= w_lost_nxt;
        end
    end

    assign s_intr1    = r_s_intr1;
    assign s_intr2    = r_s_intr2;
    assign in_service = r_in_service;
    assign pending    = r_pending;
    assign mask       = r_mask;
    assign lost_cnt   = r_lost_cnt;

endmodule
`default_nettype wire

// File: tb/tb_intr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_intr_sched
// Description : Self-checking bench for intr_sched. Directed scenarios check
//               against hand-derived constants; a randomized phase checks
//               every output each cycle against an event-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intr_sched;

    localparam int CNT_W    = 8;
    localparam int LOST_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             irq1 = 1'b0;
    logic             irq2 = 1'b0;
    logic             timer_tick = 1'b0;
    logic             stack_busy = 1'b0;
    logic             reti = 1'b0;
    logic             we_mask = 1'b0;
    logic [1:0]       mask_in = 2'b00;
    logic             s_intr1;
    logic             s_intr2;
    logic             in_service;
    logic [1:0]       pending;
    logic [1:0]       mask;
    logic [CNT_W-1:0] lost_cnt;

    int n_vec = 0;
    int n_err = 0;

    intr_sched #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq1       (irq1),
        .irq2       (irq2),
        .timer_tick (timer_tick),
        .stack_busy (stack_busy),
        .reti       (reti),
        .we_mask    (we_mask),
        .mask_in    (mask_in),
        .s_intr1    (s_intr1),
        .s_intr2    (s_intr2),
        .in_service (in_service),
        .pending    (pending),
        .mask       (mask),
        .lost_cnt   (lost_cnt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: events, a "handler busy" flag and which source was
    // just granted (0 = none). Updated once per rising edge.
    // ------------------------------------------------------------------
    bit         m_q1, m_q2, m_p1, m_p2, m_busy;
    logic [1:0] m_mask;
    int         m_lost, m_strobe;

    task automatic model_reset();
        m_q1 = 0; m_q2 = 0; m_p1 = 0; m_p2 = 0; m_busy = 0;
        m_mask = 2'b00; m_lost = 0; m_strobe = 0;
    endtask

    task automatic model_edge();
        bit r1, r2;
        int take, n;
        r1 = irq1 && !m_q1;
        r2 = (irq2 && !m_q2) || timer_tick;
        take = 0;
        if (!m_busy && !stack_busy) begin
            if (m_p1 && m_mask[0])      take = 1;
            else if (m_p2 && m_mask[1]) take = 2;
        end
        n = 0;
        if (r1) begin
            if (m_p1 && take != 1) n++;
            m_p1 = 1;
        end else if (take == 1) m_p1 = 0;
        if (r2) begin
            if (m_p2 && take != 2) n++;
            m_p2 = 1;
        end else if (take == 2) m_p2 = 0;
        m_lost = (m_lost + n > LOST_MAX) ? LOST_MAX : m_lost + n;
        // reti only counts once the strobe cycle is over.
        if (m_busy && m_strobe == 0 && reti) m_busy = 0;
        if (take != 0) m_busy = 1;
        m_strobe = take;
        if (we_mask) m_mask = mask_in;
        m_q1 = irq1;
        m_q2 = irq2;
    endtask

    // One clock: model follows the edge, outputs are sampled 1 ns later.
    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        irq1 = 0; irq2 = 0; timer_tick = 0; stack_busy = 0;
        reti = 0; we_mask = 0; mask_in = 2'b00;
        reset = 0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (s_intr1 !== 1'b0)    begin n_err++; $display("FAIL rst_s1: got %b want 0", s_intr1); end
        n_vec++; if (s_intr2 !== 1'b0)    begin n_err++; $display("FAIL rst_s2: got %b want 0", s_intr2); end
        n_vec++; if (in_service !== 1'b0) begin n_err++; $display("FAIL rst_insvc: got %b want 0", in_service); end
        n_vec++; if (pending !== 2'b00)   begin n_err++; $display("FAIL rst_pend: got %b want 00", pending); end
        n_vec++; if (mask !== 2'b00)      begin n_err++; $display("FAIL rst_mask: got %b want 00", mask); end
        n_vec++; if (lost_cnt !== 8'd0)   begin n_err++; $display("FAIL rst_lost: got %0d want 0", lost_cnt); end
        model_reset();
        reset = 1;
        clk_step();
        n_vec++; if (pending !== 2'b00)   begin n_err++; $display("FAIL rst_idle_pend: got %b want 00", pending); end
    endtask

    task automatic test_single();
        we_mask = 1; mask_in = 2'b11;
        clk_step();
        we_mask = 0;
        n_vec++; if (mask !== 2'b11) begin n_err++; $display("FAIL single_mask: got %b want 11", mask); end
        irq1 = 1;
        clk_step();
        irq1 = 0;
        n_vec++; if (pending !== 2'b01) begin n_err++; $display("FAIL single_pend: got %b want 01", pending); end
        n_vec++; if (s_intr1 !== 1'b0)  begin n_err++; $display("FAIL single_early: got %b want 0", s_intr1); end
        clk_step();
        n_vec++; if (s_intr1 !== 1'b1)    begin n_err++; $display("FAIL single_s1: got %b want 1", s_intr1); end
        n_vec++; if (s_intr2 !== 1'b0)    begin n_err++; $display("FAIL single_s2: got %b want 0", s_intr2); end
        n_vec++; if (in_service !== 1'b1) begin n_err++; $display("FAIL single_insvc: got %b want 1", in_service); end
        n_vec++; if (pending !== 2'b00)   begin n_err++; $display("FAIL single_clr: got %b want 00", pending); end
        clk_step();
        n_vec++; if (s_intr1 !== 1'b0)    begin n_err++; $display("FAIL single_onecyc: got %b want 0", s_intr1); end
        n_vec++; if (in_service !== 1'b1) begin n_err++; $display("FAIL single_svc: got %b want 1", in_service); end
        reti = 1;
        clk_step();
        reti = 0;
        n_vec++; if (in_service !== 1'b0) begin n_err++; $display("FAIL single_reti: got %b want 0", in_service); end
    endtask

    task automatic test_both();
        irq1 = 1; irq2 = 1;
        clk_step();
        irq1 = 0; irq2 = 0;
        n_vec++; if (pending !== 2'b11) begin n_err++; $display("FAIL both_pend: got %b want 11", pending); end
        clk_step();
        n_vec++; if ({s_intr2, s_intr1} !== 2'b01) begin n_err++; $display("FAIL both_prio: got %b want 01", {s_intr2, s_intr1}); end
        n_vec++; if (pending !== 2'b10) begin n_err++; $display("FAIL both_pend2: got %b want 10", pending); end
        repeat (2) clk_step();
        n_vec++; if (s_intr2 !== 1'b0) begin n_err++; $display("FAIL both_nonest: got %b want 0", s_intr2); end
        reti = 1;
        clk_step();
        reti = 0;
        n_vec++; if (in_service !== 1'b0) begin n_err++; $display("FAIL both_idle: got %b want 0", in_service); end
        n_vec++; if (s_intr2 !== 1'b0)    begin n_err++; $display("FAIL both_gap: got %b want 0", s_intr2); end
        clk_step();
        n_vec++; if ({s_intr2, s_intr1} !== 2'b10) begin n_err++; $display("FAIL both_s2: got %b want 10", {s_intr2, s_intr1}); end
        n_vec++; if (pending !== 2'b00) begin n_err++; $display("FAIL both_pend3: got %b want 00", pending); end
        clk_step();
        reti = 1;
        clk_step();
        reti = 0;
        n_vec++; if (in_service !== 1'b0) begin n_err++; $display("FAIL both_end: got %b want 0", in_service); end
    endtask

    task automatic test_mask();
        we_mask = 1; mask_in = 2'b01;
        clk_step();
        we_mask = 0;
        timer_tick = 1;
        clk_step();
        timer_tick = 0;
        n_vec++; if (pending !== 2'b10) begin n_err++; $display("FAIL mask_pend: got %b want 10", pending); end
        repeat (2) clk_step();
        n_vec++; if (s_intr2 !== 1'b0 || in_service !== 1'b0) begin n_err++; $display("FAIL mask_block: got %b%b want 00", s_intr2, in_service); end
        we_mask = 1; mask_in = 2'b11;
        clk_step();
        we_mask = 0;
        n_vec++; if (s_intr2 !== 1'b0) begin n_err++; $display("FAIL mask_lag: got %b want 0", s_intr2); end
        clk_step();
        n_vec++; if (s_intr2 !== 1'b1) begin n_err++; $display("FAIL mask_s2: got %b want 1", s_intr2); end
        clk_step();
        reti = 1;
        clk_step();
        reti = 0;
    endtask

    task automatic test_stack_busy();
        stack_busy = 1;
        irq1 = 1;
        clk_step();
        irq1 = 0;
        n_vec++; if (pending !== 2'b01) begin n_err++; $display("FAIL busy_pend: got %b want 01", pending); end
        for (int i = 0; i < 3; i++) begin
            clk_step();
            n_vec++; if (s_intr1 !== 1'b0) begin n_err++; $display("FAIL busy_hold%0d: got %b want 0", i, s_intr1); end
        end
        stack_busy = 0;
        clk_step();
        n_vec++; if (s_intr1 !== 1'b1) begin n_err++; $display("FAIL busy_release: got %b want 1", s_intr1); end
        clk_step();
        reti = 1;
        clk_step();
        reti = 0;
    endtask

    task automatic test_lost();
        apply_reset();
        we_mask = 1; mask_in = 2'b01;
        clk_step();
        we_mask = 0;
        irq1 = 1;
        clk_step();
        irq1 = 0;
        repeat (2) clk_step();
        n_vec++; if (in_service !== 1'b1) begin n_err++; $display("FAIL lost_svc: got %b want 1", in_service); end
        for (int k = 0; k < 3; k++) begin
            irq2 = 1; clk_step();
            irq2 = 0; clk_step();
        end
        n_vec++; if (pending !== 2'b10)  begin n_err++; $display("FAIL lost_pend: got %b want 10", pending); end
        n_vec++; if (lost_cnt !== 8'd2)  begin n_err++; $display("FAIL lost_two: got %0d want 2", lost_cnt); end
        irq1 = 1; clk_step();
        irq1 = 0; clk_step();
        irq1 = 1; irq2 = 1;
        clk_step();
        irq1 = 0; irq2 = 0;
        n_vec++; if (lost_cnt !== 8'd4)  begin n_err++; $display("FAIL lost_dual: got %0d want 4", lost_cnt); end
        clk_step();
        timer_tick = 1;
        repeat (250) clk_step();
        n_vec++; if (lost_cnt !== 8'd254) begin n_err++; $display("FAIL lost_254: got %0d want 254", lost_cnt); end
        repeat (50) clk_step();
        timer_tick = 0;
        n_vec++; if (lost_cnt !== 8'd255) begin n_err++; $display("FAIL lost_sat: got %0d want 255", lost_cnt); end
    endtask

    task automatic test_reset_take();
        apply_reset();
        we_mask = 1; mask_in = 2'b11;
        clk_step();
        we_mask = 0;
        irq1 = 1;
        clk_step();
        irq1 = 0;
        clk_step();
        n_vec++; if (s_intr1 !== 1'b1) begin n_err++; $display("FAIL rtake_s1: got %b want 1", s_intr1); end
        reset = 0;
        #1;
        n_vec++; if (s_intr1 !== 1'b0)    begin n_err++; $display("FAIL rtake_drop: got %b want 0", s_intr1); end
        n_vec++; if (in_service !== 1'b0) begin n_err++; $display("FAIL rtake_insvc: got %b want 0", in_service); end
        n_vec++; if (mask !== 2'b00)      begin n_err++; $display("FAIL rtake_mask: got %b want 00", mask); end
        n_vec++; if (lost_cnt !== 8'd0)   begin n_err++; $display("FAIL rtake_lost: got %0d want 0", lost_cnt); end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1;
        reti = 1;
        clk_step();
        reti = 0;
        n_vec++; if ({in_service, s_intr2, s_intr1, pending} !== 5'b00000) begin n_err++; $display("FAIL reti_idle: got %b want 00000", {in_service, s_intr2, s_intr1, pending}); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 3) == 0) irq1 = ~irq1;
            if ($urandom_range(0, 3) == 0) irq2 = ~irq2;
            timer_tick = ($urandom_range(0, 7) == 0);
            stack_busy = ($urandom_range(0, 3) == 0);
            reti       = ($urandom_range(0, 5) == 0);
            we_mask    = ($urandom_range(0, 9) == 0);
            mask_in    = 2'($urandom_range(0, 3));
            clk_step();
            n_vec++; if (s_intr1 !== (m_strobe == 1)) begin n_err++; $display("FAIL rnd_s1 c%0d: got %b want %b", c, s_intr1, (m_strobe == 1)); end
            n_vec++; if (s_intr2 !== (m_strobe == 2)) begin n_err++; $display("FAIL rnd_s2 c%0d: got %b want %b", c, s_intr2, (m_strobe == 2)); end
            n_vec++; if (in_service !== m_busy)       begin n_err++; $display("FAIL rnd_insvc c%0d: got %b want %b", c, in_service, m_busy); end
            n_vec++; if (pending !== {m_p2, m_p1})    begin n_err++; $display("FAIL rnd_pend c%0d: got %b want %b", c, pending, {m_p2, m_p1}); end
            n_vec++; if (mask !== m_mask)             begin n_err++; $display("FAIL rnd_mask c%0d: got %b want %b", c, mask, m_mask); end
            n_vec++; if (lost_cnt !== CNT_W'(m_lost)) begin n_err++; $display("FAIL rnd_lost c%0d: got %0d want %0d", c, lost_cnt, m_lost); end
        end
        irq1 = 0; irq2 = 0; timer_tick = 0; stack_busy = 0;
        reti = 0; we_mask = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_both();
        test_mask();
        test_stack_busy();
        test_lost();
        test_reset_take();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation did not finish");
    end

endmodule
`default_nettype wire
